conv_window_sequencer: RTL and testbench
========================================

Name: conv_window_sequencer

Overview:
- Frame-level controller for the 3x3 sliding-window convolution datapath. It requests row-buffer loads, primes and steps the window shifter (shift_en / shift_buffer), and hands each valid window to the convolver.
- Walks every valid output position of one frame, row-major, then signals frame completion.
- Sits between the top-level start/done interface, the row-buffer filler, the window shifter and the convolve unit.

Parameters:
IMAGE_WIDTH, 128, input image width in pixels
IMAGE_HEIGHT, 128, input image height in pixels
FILTER_SIZE, 3, kernel edge length
TIMEOUT, 1024, max cycles in any wait state before error
Derived: OUT_W = IMAGE_WIDTH-FILTER_SIZE+1; OUT_H = IMAGE_HEIGHT-FILTER_SIZE+1; CW = clog2(IMAGE_WIDTH); RW = clog2(IMAGE_HEIGHT)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  begin frame (sampled in IDLE/ERR only)
abort  in  1  synchronous abort
busy  out  1  high from leaving IDLE until DONE/ERR
done  out  1  one-cycle frame-complete pulse
error  out  1  sticky timeout flag
load_req  out  1  request FILTER_SIZE rows starting at load_row_base
load_row_base  out  RW  first image row of requested band
load_ack  in  1  band loaded into row buffer (pulse)
shift_en  out  1  one-cycle pulse: present first window of band
shift_buffer  out  1  one-cycle pulse: advance window column
window_valid  in  1  shifter window ready
new_buffer  in  1  shifter reached end of band
conv_start  out  1  one-cycle pulse: convolve current window
conv_done  in  1  convolver finished (pulse)
out_col  out  CW  output column of current window
out_row  out  RW  output row of current window

Behaviour:
- Reset (async, rst=0): state IDLE; all outputs 0; col/row counters 0; timeout counter 0.
- States: IDLE, LOAD, PRIME, WAIT_WIN, CONV, WAIT_CONV, ROW_END, DONE, ERR.
- IDLE: start=1 -> LOAD; row=0, col=0, busy=1.
- LOAD: load_req=1, load_row_base=row held until load_ack=1. Next cycle: load_req=0 -> PRIME.
- PRIME: shift_en=1 for exactly one cycle -> WAIT_WIN.
- WAIT_WIN: on window_valid=1 -> CONV.
- CONV: conv_start=1 for one cycle; out_col=col and out_row=row stable from here until the next shift_buffer -> WAIT_CONV.
- WAIT_CONV: on conv_done=1, shift_buffer=1 for one cycle.
  - If col<OUT_W-1: col+1 -> WAIT_WIN.
  - If col==OUT_W-1: -> ROW_END.
- ROW_END: on new_buffer=1:
  - If row==OUT_H-1 -> DONE.
  - Else row+1, col=0 -> LOAD.
- DONE: done=1 one cycle, busy=0 -> IDLE.
- Input events have a 1-cycle latency: each event is sampled on a clock edge and its output pulse appears on the following cycle; no combinational input-to-output paths.
- Wait states (LOAD, WAIT_WIN, WAIT_CONV, ROW_END):
  - Timeout counter clears on state entry and increments each cycle.
  - Reaching TIMEOUT -> ERR: error=1, busy=0, all pulses 0.
  - ERR holds until start=1, which clears error and behaves as start from IDLE.
- abort=1 in any state except IDLE -> IDLE next cycle. All outputs 0 (error cleared), counters 0, no done.
- abort has priority over every other event, including an in-flight handshake.
- start while busy: ignored.
- conv_done, window_valid, load_ack or new_buffer arriving outside their wait state: ignored, never latched.
- Simultaneous conv_done and timeout expiry in the same cycle: conv_done wins.
- Exactly OUT_W*OUT_H conv_start pulses, OUT_H load_reqs and OUT_W shift_buffer pulses per band per frame.
- Counters never exceed OUT_W-1 / OUT_H-1.
- Degenerate OUT_W=1: the first shift_buffer goes directly to ROW_END.

Test Plan:
1. W=6, H=5, FS=3, zero-latency responder models:
   - start -> 3 load_reqs with load_row_base 0,1,2.
   - 12 conv_start pulses; (out_row,out_col) sequence (0,0)..(0,3),(1,0)..(2,3).
   - 4 shift_buffer pulses per band.
   - One done pulse; busy falls the same cycle.
2. Random 0-20 cycle delays on load_ack/window_valid/conv_done/new_buffer -> identical pulse counts and coordinate sequence to scenario 1; load_req held high throughout each delay.
3. TIMEOUT=16, conv_done withheld at (1,2) -> error=1 and busy=0 after 16 cycles, no done. Next start clears error and a full frame of 12 conv_starts completes.
4. abort asserted in WAIT_CONV at (0,2) -> IDLE next cycle, all outputs 0, no done. Restart yields the full scenario 1 sequence from (0,0).
5. Stray conv_done during LOAD, plus start pulses mid-frame -> ignored; sequence unchanged from scenario 1.
6. rst deasserted then asserted low mid-WAIT_WIN, asynchronously between clock edges -> all outputs 0 immediately, before the next edge. Next start re-runs from row 0.

Source files
------------

// File: rtl/conv_window_sequencer.sv
// rtl/conv_window_sequencer.sv - frame-level sequencer for the sliding-window convolution datapath
module conv_window_sequencer #(
  parameter int IMAGE_WIDTH  = 128,
  parameter int IMAGE_HEIGHT = 128,
  parameter int FILTER_SIZE  = 3,
  parameter int TIMEOUT      = 1024,
  localparam int CW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1,
  localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic          load_req,
  output logic [RW-1:0] load_row_base,
  input  logic          load_ack,
  output logic          shift_en,
  output logic          shift_buffer,
  input  logic          window_valid,
  input  logic          new_buffer,
  output logic          conv_start,
  input  logic          conv_done,
  output logic [CW-1:0] out_col,
  output logic [RW-1:0] out_row
);

  localparam int OUT_W = IMAGE_WIDTH - FILTER_SIZE + 1;
  localparam int OUT_H = IMAGE_HEIGHT - FILTER_SIZE + 1;
  localparam int TW    = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(OUT_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(OUT_H - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_PRIME,
    S_WAIT_WIN,
    S_CONV,
    S_WAIT_CONV,
    S_ROW_END,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col, col_nxt;
  logic [RW-1:0] row, row_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic          shift_q, shift_nxt;
  logic          expired;

  // A wait state gives up once it has spent TIMEOUT cycles without its event
  assign expired = (tcnt == TO_LAST);

  // State, position counters, wait timer and the registered shift_buffer pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      col     <= '0;
      row     <= '0;
      tcnt    <= '0;
      shift_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      col     <= col_nxt;
      row     <= row_nxt;
      tcnt    <= tcnt_nxt;
      shift_q <= shift_nxt;
    end
  end

  // Next state; the wait timer restarts from zero whenever a wait state is entered
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    tcnt_nxt  = '0;
    shift_nxt = 1'b0;
    unique case (state)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_nxt = S_LOAD;
          col_nxt   = '0;
          row_nxt   = '0;
        end
      end
      S_LOAD: begin
        if (load_ack)     state_nxt = S_PRIME;
        else if (expired) state_nxt = S_ERR;
        else              tcnt_nxt  = tcnt + TW'(1);
      end
      S_PRIME: state_nxt = S_WAIT_WIN;
      S_WAIT_WIN: begin
        if (window_valid) state_nxt = S_CONV;
        else if (expired) state_nxt = S_ERR;
        else              tcnt_nxt  = tcnt + TW'(1);
      end
      S_CONV: state_nxt = S_WAIT_CONV;
      S_WAIT_CONV: begin
        // conv_done is tested first so a finish on the last allowed cycle still counts
        if (conv_done) begin
          shift_nxt = 1'b1;
          if (col == COL_LAST) begin
            state_nxt = S_ROW_END;
          end else begin
            col_nxt   = col + CW'(1);
            state_nxt = S_WAIT_WIN;
          end
        end else if (expired) begin
          state_nxt = S_ERR;
        end else begin
          tcnt_nxt = tcnt + TW'(1);
        end
      end
      S_ROW_END: begin
        if (new_buffer) begin
          if (row == ROW_LAST) begin
            state_nxt = S_DONE;
          end else begin
            row_nxt   = row + RW'(1);
            col_nxt   = '0;
            state_nxt = S_LOAD;
          end
        end else if (expired) begin
          state_nxt = S_ERR;
        end else begin
          tcnt_nxt = tcnt + TW'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        col_nxt   = '0;
        row_nxt   = '0;
      end
      default: state_nxt = S_IDLE;
    endcase
    // abort beats every handshake, including one completing this very cycle
    if (abort && state != S_IDLE) begin
      state_nxt = S_IDLE;
      col_nxt   = '0;
      row_nxt   = '0;
      tcnt_nxt  = '0;
      shift_nxt = 1'b0;
    end
  end

  // Outputs decode registered state only, so no input reaches an output combinationally
  assign busy          = (state == S_LOAD) || (state == S_PRIME) || (state == S_WAIT_WIN) ||
                         (state == S_CONV) || (state == S_WAIT_CONV) || (state == S_ROW_END);
  assign done          = (state == S_DONE);
  assign error         = (state == S_ERR);
  assign load_req      = (state == S_LOAD);
  assign load_row_base = (state == S_LOAD) ? row : '0;
  assign shift_en      = (state == S_PRIME);
  assign shift_buffer  = shift_q;
  assign conv_start    = (state == S_CONV);
  assign out_col       = col;
  assign out_row       = row;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb/tb_conv_window_sequencer.sv - scoreboard bench for conv_window_sequencer
module tb_conv_window_sequencer;

  localparam int W  = 6;
  localparam int H  = 5;
  localparam int FS = 3;
  localparam int TO = 16;
  localparam int OW = W - FS + 1;
  localparam int OH = H - FS + 1;
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, abort = 1'b0;
  logic load_ack = 1'b0, window_valid = 1'b0, new_buffer = 1'b0, conv_done = 1'b0;
  logic busy, done, error, load_req, shift_en, shift_buffer, conv_start;
  logic [RW-1:0] load_row_base, out_row;
  logic [CW-1:0] out_col;

  conv_window_sequencer #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .FILTER_SIZE(FS), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .error(error),
    .load_req(load_req), .load_row_base(load_row_base), .load_ack(load_ack),
    .shift_en(shift_en), .shift_buffer(shift_buffer),
    .window_valid(window_valid), .new_buffer(new_buffer),
    .conv_start(conv_start), .conv_done(conv_done),
    .out_col(out_col), .out_row(out_row)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int dmax = 0;
  bit hold_en = 0;
  int hold_r = 0, hold_c = 0;
  int exp_q[$];
  int load_q[$];
  int conv_cnt = 0, done_cnt = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int all_outs();
    return int'({busy, done, error, load_req, shift_en, shift_buffer, conv_start,
                 out_col, out_row, load_row_base});
  endfunction

  // Reference: one frame visits output positions row-major and loads each band once
  function automatic void push_frame(int n);
    for (int i = 0; i < n; i++) exp_q.push_back((i / OW) * 256 + (i % OW));
    for (int r = 0; r <= (n - 1) / OW; r++) load_q.push_back(r);
  endfunction

  // Monitor: pops the scoreboard on every DUT handshake output
  bit load_req_d = 0, load_ack_d = 0, had_band = 0;
  int sb_band = 0;
  always @(negedge clk) begin
    #1;
    if (conv_start) begin
      conv_cnt++;
      if (exp_q.size() == 0) check("conv_unexpected", 1, 0);
      else check("conv_coord", int'(out_row) * 256 + int'(out_col), exp_q.pop_front());
    end
    if (load_req && !load_req_d) begin
      if (load_q.size() == 0) check("load_unexpected", 1, 0);
      else check("load_row_base", int'(load_row_base), load_q.pop_front());
      if (had_band) check("shift_buffers_per_band", sb_band, OW);
      sb_band = 0;
      had_band = 1;
    end
    if (load_req_d && !load_req && rst) check("load_req_held_until_ack", int'(load_ack_d), 1);
    if (shift_buffer) sb_band++;
    if (done) begin
      done_cnt++;
      check("busy_low_at_done", int'(busy), 0);
      check("shift_buffers_last_band", sb_band, OW);
      had_band = 0;
    end else if (!busy) begin
      had_band = 0;
    end
    load_req_d = load_req;
    load_ack_d = load_ack;
  end

  // Row-buffer filler model
  initial forever begin
    @(negedge clk);
    if (load_req && rst) begin
      repeat ($urandom_range(dmax, 0)) @(negedge clk);
      load_ack = 1'b1;
      @(negedge clk);
      load_ack = 1'b0;
    end
  end

  // Window shifter model: a window per step, end-of-band after the OW-th step
  int nsb = 0;
  initial forever begin
    @(negedge clk);
    if (shift_en) begin
      nsb = 0;
      repeat (1 + $urandom_range(dmax, 0)) @(negedge clk);
      window_valid = 1'b1;
      @(negedge clk);
      window_valid = 1'b0;
    end else if (shift_buffer) begin
      nsb++;
      repeat ($urandom_range(dmax, 0)) @(negedge clk);
      if (nsb == OW) new_buffer = 1'b1;
      else window_valid = 1'b1;
      @(negedge clk);
      new_buffer = 1'b0;
      window_valid = 1'b0;
    end
  end

  // Convolver model, optionally silent at one chosen position
  initial forever begin
    @(negedge clk);
    if (conv_start && !(hold_en && out_row == RW'(hold_r) && out_col == CW'(hold_c))) begin
      repeat (1 + $urandom_range(dmax, 0)) @(negedge clk);
      conv_done = 1'b1;
      @(negedge clk);
      conv_done = 1'b0;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_full(string tag);
    int c0, d0, k;
    c0 = conv_cnt;
    d0 = done_cnt;
    push_frame(OW * OH);
    pulse_start();
    check({tag, "_busy_after_start"}, int'(busy), 1);
    check({tag, "_error_after_start"}, int'(error), 0);
    k = 0;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, int'(done), 1);
    @(negedge clk);
    #2;
    check({tag, "_busy_after_done"}, int'(busy), 0);
    check({tag, "_conv_count"}, conv_cnt - c0, OW * OH);
    check({tag, "_done_count"}, done_cnt - d0, 1);
    check({tag, "_queue_drained"}, exp_q.size() + load_q.size(), 0);
  endtask

  task automatic wait_coord(int r, int c, output bit ok);
    ok = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (conv_start && out_row == RW'(r) && out_col == CW'(c)) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int k, d0;
    #3;
    check("reset_outputs_zero", all_outs(), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outputs_zero", all_outs(), 0);

    // Zero-latency responders
    dmax = 0;
    run_full("s1");

    // Random responder delays, kept under the wait timeout
    dmax = 12;
    run_full("s2a");
    run_full("s2b");

    // Timeout: convolver never answers at (1,2)
    dmax = 3;
    hold_en = 1; hold_r = 1; hold_c = 2;
    d0 = done_cnt;
    push_frame(OW + 3);
    pulse_start();
    wait_coord(1, 2, ok);
    check("s3_reached_hold", int'(ok), 1);
    k = 0;
    while (!error && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("s3_cycles_to_error", k, TO + 1);
    check("s3_busy_in_err", int'(busy), 0);
    repeat (5) @(negedge clk);
    check("s3_error_sticky", int'(error), 1);
    check("s3_no_done", done_cnt - d0, 0);
    check("s3_queue_drained", exp_q.size() + load_q.size(), 0);
    hold_en = 0;
    run_full("s3_restart");

    // Abort while waiting for the convolver at (0,2)
    hold_en = 1; hold_r = 0; hold_c = 2;
    d0 = done_cnt;
    push_frame(3);
    pulse_start();
    wait_coord(0, 2, ok);
    check("s4_reached_hold", int'(ok), 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #2;
    check("s4_outputs_zero_after_abort", all_outs(), 0);
    repeat (30) @(negedge clk);
    check("s4_no_done", done_cnt - d0, 0);
    check("s4_queue_drained", exp_q.size() + load_q.size(), 0);
    hold_en = 0;
    run_full("s4_restart");

    // Stray conv_done during LOAD and start pulses while busy
    fork
      run_full("s5");
      begin
        bit mine;
        mine = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 400 && busy; i++) begin
          if (load_req) begin
            conv_done = 1'b1;
            mine = 1;
          end else if (mine) begin
            conv_done = 1'b0;
            mine = 0;
          end
          start = busy && (i % 7 == 3);
          @(negedge clk);
        end
        start = 1'b0;
        if (mine) conv_done = 1'b0;
      end
    join

    // Asynchronous reset between edges while waiting for a window
    dmax = 4;
    push_frame(1);
    pulse_start();
    ok = 0;
    for (k = 0; k < 500 && !ok; k++) begin
      @(negedge clk);
      ok = shift_buffer;
    end
    check("s6_reached_wait_win", int'(ok), 1);
    #2;
    rst = 1'b0;
    #1;
    check("s6_outputs_zero_async", all_outs(), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check("s6_idle_after_reset", all_outs(), 0);
    check("s6_queue_drained", exp_q.size() + load_q.size(), 0);
    run_full("s6_restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
